// File: rtl/dec_pkg.sv
// dec_pkg: shared types and helpers for the registered one-hot decoder.
//   dec_state_t : controller states (IDLE, DEC, SCAN)
//   MAX_N       : largest supported select width
//   onehot()    : index -> one-hot word, zero when idx is out of range for n bits
package dec_pkg;

    localparam int MAX_N = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        SCAN = 2'd2
    } dec_state_t;

    function automatic logic [2**MAX_N-1:0] onehot(input int idx, input int n);
        logic [2**MAX_N-1:0] r;
        r = '0;
        if (n >= 1 && n <= MAX_N && idx >= 0 && idx < (1 << n)) begin
            r[idx[MAX_N-1:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_mux2.sv
// dec_mux2: single-bit 2:1 multiplexer, leaf cell of the next-value select tree.
//   i0, i1 : data inputs
//   s      : select (0 -> i0, 1 -> i1)
//   y      : output
module dec_mux2 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered N-to-2^N one-hot decoder with scan sequencer.
// Build option: DECODER_SCAN_EN enables the SCAN state (rotation and wrap);
// without it, mode is ignored and wrap stays 0.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : clock enable, 0 holds every register
//   in_valid  : decode request for sel
//   sel       : line to decode / scan start index
//   mode      : 0 decode, 1 scan
//   out       : registered one-hot word, polarity per ACTIVE_LOW
//   out_valid : out carries a selected line
//   scan_idx  : index of the active line
//   wrap      : one-enabled-cycle pulse on scan wrap-around
//
// state | meaning
// IDLE  | no line selected, outputs deasserted
// DEC   | holding a decoded sel
// SCAN  | stepping the active line each enabled cycle
module dec_onehot_seq
    import dec_pkg::*;
#(
    parameter int N          = 2,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [N-1:0]       sel,
    input  logic               mode,
    output logic [2**N-1:0]    out,
    output logic               out_valid,
    output logic [N-1:0]       scan_idx,
    output logic               wrap
);

    localparam int OUT_W = 2**N;
    localparam logic [OUT_W-1:0] POL = {OUT_W{ACTIVE_LOW}};

    dec_state_t       state_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic             out_valid_q;
    logic [N-1:0]     scan_idx_q;
    logic             wrap_q;

    logic             mode_eff;
    logic             scan_step;
    logic             load;
    logic [OUT_W-1:0] dec_v;
    logic [OUT_W-1:0] rot_v;
    logic [OUT_W-1:0] step_v;

`ifdef DECODER_SCAN_EN
    assign mode_eff = mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign mode_eff    = 1'b0;
`endif

    assign scan_step = mode_eff && (state_q == SCAN);
    assign load      = mode_eff ? !scan_step : in_valid;

    // Everything in the tree is already in output polarity; rotating an
    // inverted one-hot word is the inverse of rotating the one-hot word.
    assign dec_v = (load ? OUT_W'(onehot(int'(sel), N)) : '0) ^ POL;
    assign rot_v = {out_q[OUT_W-2:0], out_q[OUT_W-1]};

    for (genvar b = 0; b < OUT_W; b++) begin : g_sel_tree
        dec_mux2 u_mux_step (
            .i0 (dec_v[b]),
            .i1 (rot_v[b]),
            .s  (scan_step),
            .y  (step_v[b])
        );
        dec_mux2 u_mux_hold (
            .i0 (out_q[b]),
            .i1 (step_v[b]),
            .s  (en),
            .y  (out_d[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= POL;
            out_valid_q <= 1'b0;
            scan_idx_q  <= '0;
            wrap_q      <= 1'b0;
        end else begin
            out_q <= out_d;
            if (en) begin
                if (mode_eff) begin
                    state_q     <= SCAN;
                    out_valid_q <= 1'b1;
                    if (state_q == SCAN) begin
                        scan_idx_q <= scan_idx_q + N'(1);
                        wrap_q     <= (scan_idx_q == {N{1'b1}});
                    end else begin
                        scan_idx_q <= sel;
                        wrap_q     <= 1'b0;
                    end
                end else if (in_valid) begin
                    state_q     <= DEC;
                    out_valid_q <= 1'b1;
                    scan_idx_q  <= sel;
                    wrap_q      <= 1'b0;
                end else begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    wrap_q      <= 1'b0;
                end
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign scan_idx  = scan_idx_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/dec_onehot_seq.md
# dec_onehot_seq

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. Decodes an N-bit select into a registered one-hot word with a valid flag. In scan mode it walks the active line through every output position, driving enable strobes for banks of N-addressed peripherals. It supersedes the fixed 2-to-4 mux-built decoder wherever a registered or sequenced select is needed.

## Interface
Parameters:
- N, 2, select width; legal range 1..6; output width OUT_W = 2**N (localparam)
- ACTIVE_LOW, 0, 1 = selected line is 0 and all others are 1 (polarity applied at the output register only)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  clock enable; 0 = every register holds
- in_valid  in  1  sel is valid this cycle (decode mode)
- sel  in  N  line index to decode; start index for scan
- mode  in  1  0 = decode, 1 = scan
- out  out  OUT_W  registered one-hot word (polarity per ACTIVE_LOW)
- out_valid  out  1  out carries a selected line
- scan_idx  out  N  index of the currently active line
- wrap  out  1  one-cycle pulse on scan wrap-around

## Operation
- Reset (async assert, sync release):
  - state=IDLE, out=all-deasserted (0s, or all 1s if ACTIVE_LOW), out_valid=0, scan_idx=0, wrap=0.
- State machine: IDLE, DEC, SCAN. All transitions and updates only on cycles with en=1; en=0 freezes state and all outputs.
- Priority, evaluated with en=1: mode=1 beats in_valid; in_valid is ignored while mode=1.
- mode=0, in_valid=1:
  - Next state DEC.
  - out=onehot(sel), out_valid=1, scan_idx=sel, wrap=0.
- mode=0, in_valid=0:
  - Next state IDLE.
  - out deasserted, out_valid=0, wrap=0; scan_idx holds.
- mode=1 from IDLE or DEC (scan entry):
  - Next state SCAN.
  - scan_idx=sel, out=onehot(sel), out_valid=1, wrap=0.
- mode=1 in SCAN:
  - scan_idx=scan_idx+1 mod 2**N; out rotates left by one position.
  - wrap=1 exactly on the step from 2**N-1 to 0, else 0.
- mode=0 in SCAN: leaves SCAN via the decode rules above in the same cycle.
- Invariant: out always has exactly one asserted line when out_valid=1, and none when out_valid=0.
- N=1: a scan alternates lines 0 and 1, and wrap fires every second step.

## Timing
- Latency: 1 cycle from sampled inputs to out, out_valid, scan_idx and wrap.
- No combinational path from any input to any output.
- wrap is high for exactly one enabled cycle. If en drops while wrap=1, wrap holds until the next enabled cycle.
- Reset mid-scan: outputs go to reset values immediately (asynchronously). The first enabled cycle after release follows the normal rules from IDLE.

## Configuration
- DECODER_SCAN_EN defined: SCAN state, rotation and wrap are built as described.
- DECODER_SCAN_EN undefined:
  - mode is ignored and treated as 0; the SCAN state does not exist.
  - wrap is tied to 0. scan_idx still tracks the last decoded sel.
  - Port list is unchanged.

## Structure
- Package dec_pkg holds:
  - state enum dec_state_t {IDLE, DEC, SCAN}
  - function onehot(idx, N)
  - constant max N = 6
- Sub-module dec_mux2 (2:1 mux, inputs i0, i1, s, output y). The one-hot next-value select tree (decode vs rotate vs hold) is built from dec_mux2 instances per output bit.

## Test plan
- Reset, N=2: after rst_n release, out=4'b0000, out_valid=0, scan_idx=0, wrap=0. Repeat with ACTIVE_LOW=1: out=4'b1111.
- N=3 decode: in_valid=1, sel=5 -> next cycle out=8'b0010_0000, out_valid=1. Then in_valid=0 -> out=0, out_valid=0.
- N=2 scan: mode=1, sel=2 -> out sequence 0100, 1000, 0001, 0010. wrap=1 only in the cycle out=0001.
- en gating: during a scan, en=0 for 3 cycles -> out, scan_idx and wrap frozen. Sequence resumes unchanged when en=1.
- Simultaneous events: mode=1 with in_valid=1, sel=1 (N=2) -> scan entry at index 1. Assert rst_n=0 mid-scan -> outputs reset immediately, without waiting for a clock edge.
- Build without DECODER_SCAN_EN: mode=1, in_valid=1, sel=3 -> out=4'b1000, no rotation, wrap stays 0.
